// File: rtl/pre_if_stage.sv
// Pre-IF fetch controller: one outstanding instruction request on an SRAM-like
// bus, a one-entry instruction buffer toward IF, and branch-redirect squashing.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BR_BUS_WD = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BR_BUS_WD-1:0] br_bus,
  input  logic                 fs_allowin,
  output logic                 pfs_to_fs_valid,
  output logic [63:0]          pfs_to_fs_bus,
  output logic                 inst_sram_req,
  output logic                 inst_sram_wr,
  output logic [1:0]           inst_sram_size,
  output logic [3:0]           inst_sram_wstrb,
  output logic [31:0]          inst_sram_addr,
  output logic [31:0]          inst_sram_wdata,
  input  logic                 inst_sram_addr_ok,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        addr_hs;

  assign br_taken  = br_bus[BR_BUS_WD-1];
  assign br_target = br_bus[31:0];

  // Handshake protocol: a request is accepted on a cycle where req && addr_ok;
  // exactly one data_ok follows later. A request is only raised when the
  // buffer is empty or draining, so the response always has somewhere to land.
  assign inst_sram_req   = !reset && (state_q == S_REQ) && (!buf_valid_q || fs_allowin);
  assign addr_hs         = inst_sram_req && inst_sram_addr_ok;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  assign pfs_to_fs_valid = buf_valid_q;
  assign pfs_to_fs_bus   = {buf_inst_q, buf_pc_q};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    cancel_d    = cancel_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;

    if (buf_valid_q && fs_allowin) buf_valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (addr_hs) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_WAIT;
          cancel_d = br_taken;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
          // A response for a squashed fetch, or one racing a branch, is dropped.
          if (!cancel_q && !br_taken) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = inst_sram_rdata;
            buf_pc_d    = req_pc_q;
            fetch_pc_d  = req_pc_q + 32'd4;
          end
        end else if (br_taken) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (br_taken) begin
      fetch_pc_d  = br_target;
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= 32'h0;
      cancel_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      cancel_q    <= cancel_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: fetch, backpressure, branch squashing in
// each handshake phase, stray data_ok and asynchronous reset mid-request.
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [32:0] br_bus = 33'h0;
  logic        fs_allowin = 1'b1;
  logic        pfs_to_fs_valid;
  logic [63:0] pfs_to_fs_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk(clk), .reset(reset), .br_bus(br_bus), .fs_allowin(fs_allowin),
    .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_to_fs_bus(pfs_to_fs_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  // Advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL rst_req actual=%0h required=0", inst_sram_req); end
    checks++; if (pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%0h required=0", pfs_to_fs_valid); end
    checks++; if (pfs_to_fs_bus !== 64'h0) begin errors++; $display("FAIL rst_bus actual=%0h required=0", pfs_to_fs_bus); end
    checks++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      errors++; $display("FAIL const_outs actual=%0h/%0h/%0h/%0h required=0/2/0/0", inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    inst_sram_addr_ok = 1'b1; #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin errors++; $display("FAIL ff_req actual=%0h@%0h required=1@1c000000", inst_sram_req, inst_sram_addr); end
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h02800000; #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL ff_wait_req actual=%0h required=0", inst_sram_req); end
    tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b1) begin errors++; $display("FAIL ff_valid actual=%0h required=1", pfs_to_fs_valid); end
    checks++; if (pfs_to_fs_bus !== 64'h02800000_1c000000) begin errors++; $display("FAIL ff_bus actual=%0h required=028000001c000000", pfs_to_fs_bus); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000004) begin errors++; $display("FAIL ff_next actual=%0h@%0h required=1@1c000004", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_backpressure();
    // Fetch 0x1c000004 while IF drains the first instruction.
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11110001; tick();
    inst_sram_data_ok = 1'b0; fs_allowin = 1'b0; #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bp_req actual=%0h required=0", inst_sram_req); end
    tick(); tick();
    checks++; if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_bus !== 64'h11110001_1c000004) begin
      errors++; $display("FAIL bp_hold actual=%0h/%0h required=1/111100011c000004", pfs_to_fs_valid, pfs_to_fs_bus);
    end
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bp_req2 actual=%0h required=0", inst_sram_req); end
    fs_allowin = 1'b1; #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000008) begin errors++; $display("FAIL bp_resume actual=%0h@%0h required=1@1c000008", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_branch_in_wait();
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; br_bus = {1'b1, 32'h1c000100}; tick();
    br_bus = 33'h0; tick(); tick();
    checks++; if (inst_sram_req !== 1'b0 || pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL bw_idle actual=%0h/%0h required=0/0", inst_sram_req, pfs_to_fs_valid); end
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL bw_drop actual=%0h required=0", pfs_to_fs_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin errors++; $display("FAIL bw_target actual=%0h@%0h required=1@1c000100", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_branch_with_data();
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00001;
    br_bus = {1'b1, 32'h1c000200}; tick();
    inst_sram_data_ok = 1'b0; br_bus = 33'h0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL bd_nowrite actual=%0h required=0", pfs_to_fs_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin errors++; $display("FAIL bd_target actual=%0h@%0h required=1@1c000200", inst_sram_req, inst_sram_addr); end
    // Cancel must be clear: the next response is kept.
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h22220002; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_bus !== 64'h22220002_1c000200) begin
      errors++; $display("FAIL bd_keep actual=%0h/%0h required=1/222200021c000200", pfs_to_fs_valid, pfs_to_fs_bus);
    end
    checks++; if (inst_sram_addr !== 32'h1c000204) begin errors++; $display("FAIL bd_next actual=%0h required=1c000204", inst_sram_addr); end
  endtask

  task automatic test_branch_with_addr_hs();
    // Branch in REQ without handshake: buffer cleared, no cancel.
    br_bus = {1'b1, 32'h1c000010}; tick();
    br_bus = 33'h0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL br_req_clr actual=%0h required=0", pfs_to_fs_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000010) begin errors++; $display("FAIL br_req_addr actual=%0h@%0h required=1@1c000010", inst_sram_req, inst_sram_addr); end
    inst_sram_addr_ok = 1'b1; br_bus = {1'b1, 32'h1c000300}; tick();
    inst_sram_addr_ok = 1'b0; br_bus = 33'h0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00010; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b0) begin errors++; $display("FAIL bh_drop actual=%0h required=0", pfs_to_fs_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000300) begin errors++; $display("FAIL bh_target actual=%0h@%0h required=1@1c000300", inst_sram_req, inst_sram_addr); end
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h33330003; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_bus !== 64'h33330003_1c000300 || pfs_to_fs_valid !== 1'b1) begin
      errors++; $display("FAIL bh_keep actual=%0h/%0h required=1/333300031c000300", pfs_to_fs_valid, pfs_to_fs_bus);
    end
  endtask

  task automatic test_stray_data_ok();
    fs_allowin = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h0badf00d; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_bus !== 64'h33330003_1c000300) begin errors++; $display("FAIL stray_bus actual=%0h required=333300031c000300", pfs_to_fs_bus); end
    checks++; if (inst_sram_addr !== 32'h1c000304) begin errors++; $display("FAIL stray_addr actual=%0h required=1c000304", inst_sram_addr); end
    fs_allowin = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    inst_sram_addr_ok = 1'b1; tick();
    inst_sram_addr_ok = 1'b0; #2;
    reset = 1'b1; #1;
    checks++; if (inst_sram_req !== 1'b0 || pfs_to_fs_valid !== 1'b0 || pfs_to_fs_bus !== 64'h0) begin
      errors++; $display("FAIL mr_outs actual=%0h/%0h/%0h required=0/0/0", inst_sram_req, pfs_to_fs_valid, pfs_to_fs_bus);
    end
    checks++; if (inst_sram_addr !== 32'h1c000000) begin errors++; $display("FAIL mr_addr actual=%0h required=1c000000", inst_sram_addr); end
    tick();
    reset = 1'b0; inst_sram_addr_ok = 1'b1; #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin errors++; $display("FAIL mr_first actual=%0h@%0h required=1@1c000000", inst_sram_req, inst_sram_addr); end
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h44440004; tick();
    inst_sram_data_ok = 1'b0; #1;
    checks++; if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_bus !== 64'h44440004_1c000000) begin
      errors++; $display("FAIL mr_fetch actual=%0h/%0h required=1/444400041c000000", pfs_to_fs_valid, pfs_to_fs_bus);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_branch_in_wait();
    test_branch_with_data();
    test_branch_with_addr_hs();
    test_stray_data_ok();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
